// File: rtl/sha2_multi_core.sv
// sha2_multi_core: SHA-256 compression over pre-padded 32-bit words, RoundsPerCycle rounds per clock.
// Define SHA2_MULTI_MODE224_EN to add SHA-224 IV selection and digest[7] masking.
module sha2_multi_core #(
   parameter int RoundsPerCycle = 1,
   parameter int NumRound = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sha_en,
   input  logic             mode_224,
   input  logic             hash_start,
   input  logic             wipe_secret,
   input  logic [31:0]      wipe_v,
   input  logic             word_valid,
   input  logic [31:0]      word_data,
   input  logic             word_last,
   output logic             word_ready,
   output logic [7:0][31:0] digest,
   output logic             hash_done,
   output logic             idle
);
   if ((RoundsPerCycle != 1 && RoundsPerCycle != 2 && RoundsPerCycle != 4) ||
       NumRound != 64 || NumRound % RoundsPerCycle != 0) begin : g_param_err
      $error("sha2_multi_core: RoundsPerCycle must be 1, 2 or 4 with NumRound 64");
   end
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMP, ST_UPD} state_t;
   typedef struct packed {
      logic [7:0][31:0]  h;
      logic [15:0][31:0] w;
   } st_t;
   localparam logic [5:0] Step = 6'(RoundsPerCycle);
   localparam logic [5:0] LastRound = 6'(NumRound - RoundsPerCycle);
   localparam logic [7:0][31:0] Iv256 = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
   localparam logic [31:0] CubicRootPrime [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sched_f(input logic [15:0][31:0] w);
      return (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9] +
             (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
   endfunction

   function automatic logic [7:0][31:0] round_f(input logic [7:0][31:0] h, input logic [31:0] w,
                                                input logic [31:0] k);
      logic [31:0] t1, t2;
      t1 = h[7] + (rotr(h[4], 6) ^ rotr(h[4], 11) ^ rotr(h[4], 25)) +
           ((h[4] & h[5]) ^ (~h[4] & h[6])) + k + w;
      t2 = (rotr(h[0], 2) ^ rotr(h[0], 13) ^ rotr(h[0], 22)) +
           ((h[0] & h[1]) ^ (h[0] & h[2]) ^ (h[1] & h[2]));
      return {h[6], h[5], h[4], h[3] + t1, h[2], h[1], h[0], t1 + t2};
   endfunction

   // w[0] is always the word for the round being applied; the window slides one word per round
   function automatic st_t step_f(input st_t s, input logic [5:0] t);
      st_t o;
      o = s;
      for (int j = 0; j < RoundsPerCycle; j++) begin
         o.h = round_f(o.h, o.w[0], CubicRootPrime[t + 6'(j)]);
         o.w = {(t + 6'(j) < 6'd48) ? sched_f(o.w) : 32'h0, o.w[15:1]};
      end
      return o;
   endfunction

   state_t            r_state, w_state_next;
   logic [15:0][31:0] r_w;
   logic [7:0][31:0]  r_hash, r_digest, w_iv;
   logic [5:0]        r_round;
   logic [3:0]        r_idx;
   logic              r_mode, r_last, r_done, w_mode_in;
   st_t               w_next;

`ifdef SHA2_MULTI_MODE224_EN
   localparam logic [7:0][31:0] Iv224 = {
      32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
      32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
   assign w_iv = mode_224 ? Iv224 : Iv256;
   assign w_mode_in = mode_224;
`else
   assign w_iv = Iv256;
   assign w_mode_in = 1'b0 & mode_224;
`endif

   assign w_next = step_f({r_hash, r_w}, r_round);
   assign word_ready = r_state == ST_LOAD && !wipe_secret && sha_en && !hash_start;
   assign idle = r_state == ST_IDLE && !hash_start;
   assign hash_done = r_done;

   always_comb begin
      digest = r_digest;
      digest[7] = r_mode ? 32'h0 : r_digest[7];
   end

   always_comb begin
      w_state_next = r_state;
      if (wipe_secret) w_state_next = r_state;
      else if (!sha_en) w_state_next = ST_IDLE;
      else if (hash_start) w_state_next = ST_LOAD;
      else
         case (r_state)
            ST_LOAD: w_state_next = (word_valid && r_idx == 4'd15) ? ST_COMP : ST_LOAD;
            ST_COMP: w_state_next = (r_round == LastRound) ? ST_UPD : ST_COMP;
            ST_UPD:  w_state_next = r_last ? ST_IDLE : ST_LOAD;
            default: w_state_next = r_state;
         endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_state <= ST_IDLE;
      else r_state <= w_state_next;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_w <= '0;
         r_hash <= '0;
         r_digest <= '0;
         r_round <= '0;
         r_idx <= '0;
         r_mode <= 1'b0;
         r_last <= 1'b0;
         r_done <= 1'b0;
      end else if (wipe_secret) begin
         r_w <= r_w ^ {16{wipe_v}};
         r_hash <= r_hash ^ {8{wipe_v}};
         r_digest <= r_digest ^ {8{wipe_v}};
         r_done <= 1'b0;
      end else if (!sha_en) begin
         r_w <= '0;
         r_hash <= '0;
         r_digest <= '0;
         r_round <= '0;
         r_idx <= '0;
         r_mode <= 1'b0;
         r_last <= 1'b0;
         r_done <= 1'b0;
      end else if (hash_start) begin
         r_digest <= w_iv;
         r_mode <= w_mode_in;
         r_round <= '0;
         r_idx <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_LOAD:
               if (word_valid) begin
                  r_w <= {word_data, r_w[15:1]};
                  r_idx <= r_idx + 4'd1;
                  if (r_idx == 4'd15) begin
                     r_last <= word_last;
                     r_hash <= r_digest;
                  end
               end
            ST_COMP: begin
               r_hash <= w_next.h;
               r_w <= w_next.w;
               r_round <= r_round + Step;
            end
            ST_UPD: begin
               for (int i = 0; i < 8; i++) r_digest[i] <= r_digest[i] + r_hash[i];
               r_done <= r_last;
               r_idx <= '0;
            end
            default: ;
         endcase
      end
endmodule
